// File: rtl/detect_pkg.sv
// Shared raster timing definitions: default widths, PPC legality, FSM state encoding.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a. HBLANK/VBLANK states exist only when RASTER_BLANKING_EN is defined.
package detect_pkg;

    localparam int COORD_W_DEF = 12;
    localparam int FRAME_W_DEF = 32;

`ifdef RASTER_BLANKING_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1
    } state_e;
`endif

    // Only 1, 2 and 4 pixels per beat keep h_active/PPC a pure shift.
    function automatic bit ppc_legal(input int ppc);
        return (ppc == 1) || (ppc == 2) || (ppc == 4);
    endfunction

    function automatic int ppc_log2(input int ppc);
        return (ppc == 4) ? 2 : ((ppc == 2) ? 1 : 0);
    endfunction

endpackage

// File: rtl/raster_timing_gen_if.sv
// Raster generator bundle: enable and frame config in, beat coordinates and timing flags out.
// Latency: n/a (wiring only).
// Backpressure: en is the only throttle; master is the generator, slave is the consumer.
interface raster_timing_gen_if
    import detect_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF
);
    logic               en;
    logic [COORD_W-1:0] cfg_h_active;
    logic [COORD_W-1:0] cfg_v_active;
    logic [COORD_W-1:0] cfg_h_blank;
    logic [COORD_W-1:0] cfg_v_blank;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [FRAME_W-1:0] frame;
    logic               de;
    logic               hsync;
    logic               vsync;
    logic               eol;
    logic               eof;
    logic               cfg_err;

    modport master (
        input  en, cfg_h_active, cfg_v_active, cfg_h_blank, cfg_v_blank,
        output x, y, frame, de, hsync, vsync, eol, eof, cfg_err
    );

    modport slave (
        output en, cfg_h_active, cfg_v_active, cfg_h_blank, cfg_v_blank,
        input  x, y, frame, de, hsync, vsync, eol, eof, cfg_err
    );
endinterface

// File: rtl/raster_timing_gen_counter.sv
// Generic up-counter with clear, programmable step and terminal-count compare.
// Latency: count updates one cycle after clr/inc; tc is combinational from the register.
// Backpressure: none; caller gates inc/clr with its own enable. clr wins over inc.
module raster_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] step,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         tc
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over stepping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + step;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
    assign tc      = (cnt_q == last);
endmodule

// File: rtl/raster_timing_gen.sv
// Raster timing generator: walks x/y over active area (and blanking when RASTER_BLANKING_EN is defined).
// Latency: all outputs registered; first de one enabled cycle after a valid config is latched.
// Backpressure: en=0 freezes every counter/state and forces de/hsync/vsync/eol/eof low.
module raster_timing_gen
    import detect_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int PPC     = 1
) (
    input  logic                clk,
    input  logic                reset,
    raster_timing_gen_if.master rif
);
    localparam bit                 PPC_OK = ppc_legal(PPC);
    localparam logic [COORD_W-1:0] STEP   = COORD_W'(PPC);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    typedef struct packed {
        logic [COORD_W-1:0] h_act;
        logic [COORD_W-1:0] v_act;
        logic [COORD_W-1:0] h_blk;
        logic [COORD_W-1:0] v_blk;
    } cfg_t;

    state_e             state_q, state_d;
    cfg_t               cfg_q, cfg_d, cfg_in;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               cfg_err_q, cfg_err_d;
    logic               de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic               eol_q, eol_d, eof_q, eof_d;
    logic               in_valid;
    logic               x_clr, x_inc, x_tc, y_clr, y_inc, y_tc;
    logic [COORD_W-1:0] x_cnt, x_nxt, y_cnt, y_nxt;

    // Config as seen at a latch point; blanking reads as zero when the feature is compiled out.
    always_comb begin
        cfg_in.h_act = rif.cfg_h_active;
        cfg_in.v_act = rif.cfg_v_active;
`ifdef RASTER_BLANKING_EN
        cfg_in.h_blk = rif.cfg_h_blank;
        cfg_in.v_blk = rif.cfg_v_blank;
`else
        cfg_in.h_blk = '0;
        cfg_in.v_blk = '0;
`endif
    end

`ifndef RASTER_BLANKING_EN
    logic unused_blank;
    assign unused_blank = ^{rif.cfg_h_blank, rif.cfg_v_blank};
`endif

    assign in_valid = PPC_OK && (cfg_in.h_act != '0) && (cfg_in.v_act != '0)
                      && ((cfg_in.h_act & (STEP - ONE)) == '0);

    raster_counter #(.W(COORD_W)) u_x_cnt (
        .clk(clk), .reset(reset), .clr(x_clr), .inc(x_inc), .step(STEP),
        .last(cfg_q.h_act - STEP), .cnt(x_cnt), .cnt_nxt(x_nxt), .tc(x_tc)
    );

    raster_counter #(.W(COORD_W)) u_y_cnt (
        .clk(clk), .reset(reset), .clr(y_clr), .inc(y_inc), .step(ONE),
        .last(cfg_q.v_act - ONE), .cnt(y_cnt), .cnt_nxt(y_nxt), .tc(y_tc)
    );

`ifdef RASTER_BLANKING_EN
    localparam int SHIFT = ppc_log2(PPC);
    logic               b_clr, b_inc, b_tc, l_clr, l_inc, l_tc;
    logic [COORD_W-1:0] b_cnt, b_nxt, l_cnt, l_nxt, b_last;
    logic               unused_blank_cnt;

    // b counts beats of an HBLANK, or beats of one blank line during VBLANK; l counts VBLANK lines.
    assign b_last = (state_q == ST_HBLANK) ? (cfg_q.h_blk - ONE)
                                           : ((cfg_q.h_act >> SHIFT) + cfg_q.h_blk - ONE);
    assign unused_blank_cnt = ^{b_cnt, b_nxt, l_cnt, l_nxt};

    raster_counter #(.W(COORD_W)) u_b_cnt (
        .clk(clk), .reset(reset), .clr(b_clr), .inc(b_inc), .step(ONE),
        .last(b_last), .cnt(b_cnt), .cnt_nxt(b_nxt), .tc(b_tc)
    );

    raster_counter #(.W(COORD_W)) u_l_cnt (
        .clk(clk), .reset(reset), .clr(l_clr), .inc(l_inc), .step(ONE),
        .last(cfg_q.v_blk - ONE), .cnt(l_cnt), .cnt_nxt(l_nxt), .tc(l_tc)
    );
`endif

    // Next state, config latch, frame count and counter controls; nothing moves while en=0.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        frame_d   = frame_q;
        cfg_err_d = cfg_err_q;
        x_clr     = 1'b0;
        x_inc     = 1'b0;
        y_clr     = 1'b0;
        y_inc     = 1'b0;
`ifdef RASTER_BLANKING_EN
        b_clr     = 1'b0;
        b_inc     = 1'b0;
        l_clr     = 1'b0;
        l_inc     = 1'b0;
`endif
        if (rif.en) begin
            case (state_q)
                ST_IDLE: begin
                    cfg_d     = cfg_in;
                    cfg_err_d = !in_valid;
                    if (in_valid) begin
                        state_d = ST_ACTIVE;
                        x_clr   = 1'b1;
                        y_clr   = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!x_tc) begin
                        x_inc = 1'b1;
                    end else if (!y_tc) begin
                        x_clr = 1'b1;
                        y_inc = 1'b1;
`ifdef RASTER_BLANKING_EN
                        if (cfg_q.h_blk != '0) begin
                            x_clr   = 1'b0;
                            y_inc   = 1'b0;
                            b_clr   = 1'b1;
                            state_d = ST_HBLANK;
                        end
`endif
                    end else begin
                        // End of frame: count it, re-latch and re-check config.
                        frame_d   = frame_q + 1'b1;
                        cfg_d     = cfg_in;
                        cfg_err_d = !in_valid;
                        x_clr     = 1'b1;
                        y_clr     = 1'b1;
                        state_d   = in_valid ? ST_ACTIVE : ST_IDLE;
`ifdef RASTER_BLANKING_EN
                        if (in_valid && (cfg_in.v_blk != '0)) begin
                            b_clr   = 1'b1;
                            l_clr   = 1'b1;
                            state_d = ST_VBLANK;
                        end
`endif
                    end
                end
`ifdef RASTER_BLANKING_EN
                ST_HBLANK: begin
                    if (b_tc) begin
                        state_d = ST_ACTIVE;
                        x_clr   = 1'b1;
                        y_inc   = 1'b1;
                    end else begin
                        b_inc = 1'b1;
                    end
                end
                ST_VBLANK: begin
                    if (b_tc) begin
                        b_clr = 1'b1;
                        if (l_tc) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            l_inc = 1'b1;
                        end
                    end else begin
                        b_inc = 1'b1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Timing flags for the beat being loaded into the counters this cycle.
    always_comb begin
        de_d    = rif.en && (state_d == ST_ACTIVE);
        hsync_d = de_d && (x_nxt == '0);
        vsync_d = hsync_d && (y_nxt == '0);
        eol_d   = de_d && (x_nxt == cfg_d.h_act - STEP);
        eof_d   = eol_d && (y_nxt == cfg_d.v_act - ONE);
    end

    // State, config, frame and output flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            frame_q   <= '0;
            cfg_err_q <= 1'b0;
            de_q      <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            frame_q   <= frame_d;
            cfg_err_q <= cfg_err_d;
            de_q      <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
        end
    end

    assign rif.x       = x_cnt;
    assign rif.y       = y_cnt;
    assign rif.frame   = frame_q;
    assign rif.de      = de_q;
    assign rif.hsync   = hsync_q;
    assign rif.vsync   = vsync_q;
    assign rif.eol     = eol_q;
    assign rif.eof     = eof_q;
    assign rif.cfg_err = cfg_err_q;
endmodule

// File: doc/raster_timing_gen.md
RASTER_TIMING_GEN -- requirements
Module: raster_timing_gen

Interface
REQ-001 The block SHALL have parameter COORD_W, default 12, meaning the x/y coordinate width.
REQ-002 The block SHALL have parameter FRAME_W, default 32, meaning the frame counter width.
REQ-003 The block SHALL have parameter PPC, default 1, legal 1/2/4, meaning pixels per clock beat.
REQ-004 The block SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port en  in  1  advance enable; low freezes all state.
REQ-007 The block SHALL have ports cfg_h_active, cfg_v_active  in  COORD_W  active pixels per line, active lines per frame.
REQ-008 The block SHALL have ports cfg_h_blank, cfg_v_blank  in  COORD_W  blank beats per line, blank lines per frame.
REQ-009 The block SHALL have ports x, y  out  COORD_W  coordinate of the first pixel of the current beat.
REQ-010 The block SHALL have port frame  out  FRAME_W  count of completed frames.
REQ-011 The block SHALL have ports de, hsync, vsync, eol, eof, cfg_err  out  1 each  data enable, line start, frame start, line end, frame end, config error.

Function
REQ-012 All outputs SHALL be registered; states: IDLE, ACTIVE, HBLANK, VBLANK.
REQ-013 In IDLE with en=1, the block SHALL latch all cfg_* inputs.
REQ-014 Latched config SHALL be invalid if h_active=0, v_active=0, or h_active is not a multiple of PPC.
- Invalid: stay IDLE, cfg_err=1.
- Valid: clear cfg_err, enter ACTIVE; x=0, y=0, de=1 on the next cycle (1-cycle latency).
REQ-015 In ACTIVE, each en=1 cycle SHALL advance x by PPC with de=1.
REQ-016 hsync SHALL be 1 on every beat with x=0 and de=1.
REQ-017 vsync SHALL be 1 on the beat with x=0, y=0 and de=1.
REQ-018 eol SHALL be 1 on the beat with x=h_active-PPC.
REQ-019 eof SHALL be 1 on the beat that also has eol=1 and y=v_active-1.
REQ-020 After eol on a non-last line, the block SHALL enter HBLANK if h_blank>0, else start the next line (x=0, y+1) on the next beat.
REQ-021 HBLANK SHALL last exactly h_blank enabled cycles with de=0 and x/y held, then return to ACTIVE with x=0, y+1.
REQ-022 After eof, the block SHALL increment frame (wrapping 2^FRAME_W-1 to 0), re-latch cfg_*, and perform the REQ-014 validity check.
REQ-023 After eof, the block SHALL enter VBLANK for v_blank*(h_active/PPC + h_blank) enabled cycles when v_blank>0, else go directly to ACTIVE at x=0, y=0.
REQ-024 With en=0, the block SHALL hold all state and counters and force de, hsync, vsync, eol, eof to 0; resuming en=1 SHALL continue exactly where it left off.
REQ-025 cfg_* changes mid-frame SHALL have no effect until the next latch point.
REQ-026 h_active/PPC SHALL be computed by shift; all counters SHALL be COORD_W wide with no overflow for legal config.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL enter IDLE with x=0, y=0, frame=0, de=hsync=vsync=eol=eof=cfg_err=0.
REQ-028 Reset SHALL take priority over en, including mid-frame and mid-blank; the first de SHALL follow the REQ-014 latency after release.

Configuration
REQ-029 Macro RASTER_BLANKING_EN defined: HBLANK/VBLANK SHALL behave per REQ-020..REQ-023.
REQ-030 Macro RASTER_BLANKING_EN undefined: the blanking states SHALL not exist and cfg_h_blank/cfg_v_blank SHALL remain as ports but be ignored (treated as 0).

Structure
REQ-031 COORD_W/FRAME_W defaults, the PPC legality check and the state enum SHALL live in a shared package detect_pkg.
REQ-032 A single sub-module raster_counter (enable, clear, step, terminal-count flag) SHALL be instantiated for the x, y and blank counters.

Verification
REQ-033 PPC=1, 4x2 frame, no blanking, en=1: x,y SHALL be (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); vsync on beat 0; eol on beats 3 and 7; eof on beat 7; frame=1 on beat 8.
REQ-034 PPC=2, h_active=4, h_blank=3, v_active=2: beats x=0,2, then 3 de=0 beats, then x=0 y=1 with hsync=1.
REQ-035 cfg_h_active=3 with PPC=2: cfg_err SHALL be 1 and de SHALL stay 0; correcting to 4 SHALL start the frame on the next en cycle.
REQ-036 Drop en for 5 cycles at x=2,y=1: de=0 throughout; on resume the next beat SHALL be x=3,y=1.
REQ-037 Assert reset mid-HBLANK: the next cycle SHALL show all-zero outputs and frame=0.
REQ-038 FRAME_W=2, run 4 frames: frame SHALL go 1,2,3,0.
